// File: rtl/fifo_flush_pkg.sv
// fifo_flush_pkg
//   Shared types and defaults for the FIFO flush scheduler.
//   - state_t   : scheduler FSM states (3-bit encoding)
//   - cnt_width : width of the single shared phase counter
//   - DEF_*     : default phase lengths
package fifo_flush_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int DEF_PULSE_LEN  = 4;
    localparam int DEF_SETTLE_LEN = 8;
    localparam int DEF_TIMEOUT    = 256;

    // One counter serves every timed phase, so it must hold the largest
    // terminal value of the three.
    function automatic int cnt_width(input int pulse_len, input int settle_len,
                                     input int timeout);
        int m;
        m = pulse_len;
        if (settle_len > m) m = settle_len;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_flush_sched.sv
// fifo_flush_sched
//   Write-clock-domain scheduler sharing the FIFO reset resource between
//   N_REQ flush requesters. Pending requests are coalesced into one flush,
//   a registered reset request is sent to the FIFO reset controller, the
//   returned write-side reset is tracked through its rise and fall, writes
//   are blocked meanwhile, and every served requester is acked.
//
// Ports
//   clk, rst        write clock; asynchronous active-high reset
//   flush_req       per-requester one-cycle request pulses
//   flush_ack       per-requester one-cycle ack pulses (DONE cycle)
//   flush_err       qualifies flush_ack: 1 = flush ended by timeout
//   busy            scheduler not idle
//   wr_block        writers must not push (ASSERT through DONE)
//   fifo_rst_req    registered reset request to the reset controller
//   fifo_rst_in     write-side reset returned by the controller
//   timeout_sticky  set on any timeout, cleared by clr_timeout
//   clr_timeout     clears timeout_sticky; a same-cycle set wins
//
// Request/ack protocol: a requester pulses its flush_req bit for one cycle
// and may not assume anything until its flush_ack bit pulses. The pulse is
// latched into a pending bit; the flush that captures it acks it exactly
// once. A request made while its bit is already being flushed is held for
// one further flush rather than merged into the running one.
module fifo_flush_sched
    import fifo_flush_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int PULSE_LEN  = DEF_PULSE_LEN,
    parameter int SETTLE_LEN = DEF_SETTLE_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter bit AUTO_INIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] flush_req,
    output logic [N_REQ-1:0] flush_ack,
    output logic             flush_err,
    output logic             busy,
    output logic             wr_block,
    output logic             fifo_rst_req,
    input  logic             fifo_rst_in,
    output logic             timeout_sticky,
    input  logic             clr_timeout
);

    localparam int CW = cnt_width(PULSE_LEN, SETTLE_LEN, TIMEOUT);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_LEN - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] active_q, active_d;
    logic             err_q, err_d;
    logic             auto_q, auto_d;
    logic             sticky_q, sticky_d;
    logic             rst_req_q, rst_req_d;
    logic             timeout_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q | flush_req;
        active_d    = active_q;
        err_d       = err_q;
        auto_d      = auto_q;
        sticky_d    = sticky_q;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // fifo_rst_in rising here is an external reset and is ignored.
                if (pending_d != '0 || auto_q) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    active_d  = pending_d;
                    pending_d = '0;
                    auto_d    = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_HI: begin
                if (fifo_rst_in) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Give up rather than re-pulse: the controller is stuck.
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!fifo_rst_in) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                active_d = '0;
                err_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear first so that a timeout in the same cycle takes priority.
        if (clr_timeout) sticky_d = 1'b0;
        if (timeout_hit) sticky_d = 1'b1;

        // Decoded from the next state so the request leaves a flop directly.
        rst_req_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            err_q     <= 1'b0;
            auto_q    <= AUTO_INIT;
            sticky_q  <= 1'b0;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            err_q     <= err_d;
            auto_q    <= auto_d;
            sticky_q  <= sticky_d;
            rst_req_q <= rst_req_d;
        end
    end

    assign flush_ack      = (state_q == ST_DONE) ? active_q : '0;
    assign flush_err      = (state_q == ST_DONE) && err_q;
    assign busy           = (state_q != ST_IDLE);
    assign wr_block       = (state_q != ST_IDLE);
    assign fifo_rst_req   = rst_req_q;
    assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_fifo_flush_sched.sv
module tb_fifo_flush_sched;

  localparam int N         = 3;
  localparam int P         = 4;
  localparam int S         = 8;
  localparam int TO        = 64;
  localparam int RISE_DLY  = 5;
  localparam int HI_LEN    = 10;
  localparam int T_HI      = RISE_DLY - P + 1;
  localparam int T_LO      = HI_LEN;
  localparam int FLUSH_LEN = P + T_HI + T_LO + S + 1;
  localparam int TO_LEN    = P + TO + 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] flush_req;
  logic [N-1:0] flush_ack;
  logic flush_err, busy, wr_block, fifo_rst_req, fifo_rst_in;
  logic timeout_sticky, clr_timeout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_flush_sched #(
    .N_REQ(N), .PULSE_LEN(P), .SETTLE_LEN(S), .TIMEOUT(TO), .AUTO_INIT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_ack(flush_ack),
    .flush_err(flush_err), .busy(busy), .wr_block(wr_block),
    .fifo_rst_req(fifo_rst_req), .fifo_rst_in(fifo_rst_in),
    .timeout_sticky(timeout_sticky), .clr_timeout(clr_timeout)
  );

  // ---------------- reset controller model ----------------
  logic ctl_level = 1'b0;
  logic ext_level = 1'b0;
  logic ctl_off = 1'b0;
  logic prev_req = 1'b0;
  int ctl_rise = 0;
  int ctl_hi = 0;

  assign fifo_rst_in = ctl_level | ext_level;

  always @(negedge clk) begin
    if (rst) begin
      ctl_level = 1'b0; ctl_rise = 0; ctl_hi = 0; prev_req = 1'b0;
    end else begin
      if (fifo_rst_req && !prev_req && !ctl_off) begin
        ctl_rise = RISE_DLY;
      end else if (ctl_rise > 0) begin
        ctl_rise = ctl_rise - 1;
        if (ctl_rise == 0) begin ctl_level = 1'b1; ctl_hi = HI_LEN; end
      end else if (ctl_hi > 0) begin
        ctl_hi = ctl_hi - 1;
        if (ctl_hi == 0) ctl_level = 1'b0;
      end
      prev_req = fifo_rst_req;
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int start; int done; logic [N-1:0] ack; logic err;
  } exp_t;
  typedef struct {
    int done; int first_req; int pulse; int wrb; logic [N-1:0] ack; logic err;
  } act_t;

  exp_t exp_q[$];
  act_t act_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: a flush starts on any idle cycle with something to do
  // and takes a fixed, formula-derived number of cycles.
  logic [N-1:0] m_pending = '0;
  int m_free_at = 0;
  logic m_auto = 1'b1;
  logic m_to = 1'b0;

  // ---------------- output monitor ----------------
  act_t cur;
  logic mon_in = 1'b0;
  int stray = 0;
  int ack_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_in = 1'b0;
    end else begin
      if (busy) begin
        if (!mon_in) begin
          mon_in = 1'b1; cur.pulse = 0; cur.wrb = 0; cur.first_req = -1;
        end
        if (fifo_rst_req) begin
          cur.pulse = cur.pulse + 1;
          if (cur.first_req < 0) cur.first_req = cyc;
        end
        if (wr_block) cur.wrb = cur.wrb + 1;
        cur.done = cyc; cur.ack = flush_ack; cur.err = flush_err;
      end else if (mon_in) begin
        act_q.push_back(cur);
        mon_in = 1'b0;
      end
      if (!busy && (fifo_rst_req || wr_block)) stray = stray + 1;
      if (flush_ack != '0) ack_seen = ack_seen + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_step(input logic [N-1:0] r);
    exp_t e;
    if (cyc >= m_free_at && ((m_pending | r) != '0 || m_auto)) begin
      e.start = cyc;
      e.ack   = m_pending | r;
      e.err   = m_to;
      e.done  = cyc + (m_to ? TO_LEN : FLUSH_LEN);
      exp_q.push_back(e);
      m_free_at = e.done + 1;
      m_pending = '0;
      m_auto    = 1'b0;
    end else begin
      m_pending = m_pending | r;
    end
  endtask

  task automatic drive_cycle(input logic [N-1:0] r);
    flush_req = r;
    model_step(r);
    @(negedge clk);
  endtask

  task automatic drain();
    while (cyc < m_free_at + 3) drive_cycle('0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (fifo_rst_req !== 1'b0) $display("FAIL reset fifo_rst_req: got %b want 0", fifo_rst_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_block !== 1'b0) $display("FAIL reset wr_block: got %b want 0", wr_block); else n_pass++;
    n_checks++; if (flush_ack !== 3'b000) $display("FAIL reset flush_ack: got %b want 000", flush_ack); else n_pass++;
    n_checks++; if (flush_err !== 1'b0) $display("FAIL reset flush_err: got %b want 0", flush_err); else n_pass++;
    n_checks++; if (timeout_sticky !== 1'b0) $display("FAIL reset timeout_sticky: got %b want 0", timeout_sticky); else n_pass++;
  endtask

  task automatic test_auto_init();
    exp_t e; act_t a;
    rst = 1'b0;
    m_pending = '0; m_free_at = 0; m_auto = 1'b1; m_to = 1'b0;
    drain();
    n_checks++; if (busy !== 1'b0) $display("FAIL auto busy_after: got %b want 0", busy); else n_pass++;
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL auto count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (a.done !== e.done) $display("FAIL auto done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL auto ack: got %b want %b", a.ack, e.ack); else n_pass++;
      n_checks++; if (a.pulse !== P) $display("FAIL auto pulse_len: got %0d want %0d", a.pulse, P); else n_pass++;
      n_checks++; if (a.wrb !== e.done - e.start) $display("FAIL auto wr_block_len: got %0d want %0d", a.wrb, e.done - e.start); else n_pass++;
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_single();
    exp_t e; act_t a;
    drive_cycle(3'b010);
    drain();
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL single count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (a.first_req !== e.start + 1) $display("FAIL single req_rise: got %0d want %0d", a.first_req, e.start + 1); else n_pass++;
      n_checks++; if (a.done !== e.done) $display("FAIL single done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL single ack: got %b want %b", a.ack, e.ack); else n_pass++;
      n_checks++; if (a.err !== e.err) $display("FAIL single err: got %b want %b", a.err, e.err); else n_pass++;
      n_checks++; if (a.pulse !== P) $display("FAIL single pulse_len: got %0d want %0d", a.pulse, P); else n_pass++;
      n_checks++; if (a.wrb !== e.done - e.start) $display("FAIL single wr_block_len: got %0d want %0d", a.wrb, e.done - e.start); else n_pass++;
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_coalesce();
    exp_t e; act_t a;
    int n;
    n = cyc;
    drive_cycle(3'b010);
    drive_cycle(3'b000);
    drive_cycle(3'b001);
    drive_cycle(3'b100);
    // Second flush starts right after the first DONE; request 010 lands in its WAIT_LO.
    while (cyc < n + FLUSH_LEN + 1 + 1 + P + T_HI + 4) drive_cycle('0);
    drive_cycle(3'b010);
    drain();
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL coalesce count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (a.done !== e.done) $display("FAIL coalesce done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL coalesce ack: got %b want %b", a.ack, e.ack); else n_pass++;
      n_checks++; if (a.pulse !== P) $display("FAIL coalesce pulse_len: got %0d want %0d", a.pulse, P); else n_pass++;
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_ext_idle();
    ext_level = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle('0);
      n_checks++; if (busy !== 1'b0) $display("FAIL ext_idle busy: got %b want 0", busy); else n_pass++;
    end
    ext_level = 1'b0;
    repeat (4) drive_cycle('0);
    n_checks++; if (act_q.size() != 0) $display("FAIL ext_idle flushes: got %0d want 0", act_q.size()); else n_pass++;
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    exp_t e; act_t a;
    int n;
    ctl_off = 1'b1; m_to = 1'b1;
    drive_cycle(3'b100);
    drain();
    n_checks++; if (timeout_sticky !== 1'b1) $display("FAIL timeout sticky_set: got %b want 1", timeout_sticky); else n_pass++;
    clr_timeout = 1'b1;
    drive_cycle('0);
    clr_timeout = 1'b0;
    n_checks++; if (timeout_sticky !== 1'b0) $display("FAIL timeout sticky_clear: got %b want 0", timeout_sticky); else n_pass++;
    // Clear requested in the very cycle the next timeout fires: the set wins.
    n = cyc;
    drive_cycle(3'b001);
    while (cyc < n + TO_LEN + 3) begin
      clr_timeout = (cyc == n + P + TO);
      drive_cycle('0);
    end
    clr_timeout = 1'b0;
    n_checks++; if (timeout_sticky !== 1'b1) $display("FAIL timeout set_beats_clear: got %b want 1", timeout_sticky); else n_pass++;
    clr_timeout = 1'b1;
    drive_cycle('0);
    clr_timeout = 1'b0;
    ctl_off = 1'b0; m_to = 1'b0;
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL timeout count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (a.done !== e.done) $display("FAIL timeout done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL timeout ack: got %b want %b", a.ack, e.ack); else n_pass++;
      n_checks++; if (a.err !== e.err) $display("FAIL timeout err: got %b want %b", a.err, e.err); else n_pass++;
      n_checks++; if (a.pulse !== P) $display("FAIL timeout pulse_len: got %0d want %0d", a.pulse, P); else n_pass++;
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    exp_t e; act_t a;
    int ack_before, exp_acks;
    logic [N-1:0] r;
    ack_before = ack_seen;
    exp_acks = 0;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 6) == 0) ? N'($urandom_range(1, 7)) : '0;
      drive_cycle(r);
    end
    drain();
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL random count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      if (e.ack != '0) exp_acks++;
      n_checks++; if (a.done !== e.done) $display("FAIL random done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL random ack: got %b want %b", a.ack, e.ack); else n_pass++;
      n_checks++; if (a.err !== e.err) $display("FAIL random err: got %b want %b", a.err, e.err); else n_pass++;
      n_checks++; if (a.first_req !== e.start + 1) $display("FAIL random req_rise: got %0d want %0d", a.first_req, e.start + 1); else n_pass++;
      n_checks++; if (a.wrb !== e.done - e.start) $display("FAIL random wr_block_len: got %0d want %0d", a.wrb, e.done - e.start); else n_pass++;
    end
    n_checks++; if (ack_seen - ack_before !== exp_acks) $display("FAIL random ack_pulses: got %0d want %0d", ack_seen - ack_before, exp_acks); else n_pass++;
    n_checks++; if (timeout_sticky !== 1'b0) $display("FAIL random sticky: got %b want 0", timeout_sticky); else n_pass++;
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    exp_t e; act_t a;
    int n, ack_before;
    n = cyc;
    drive_cycle(3'b001);
    while (cyc < n + 1 + RISE_DLY + 4) drive_cycle('0);
    ack_before = ack_seen;
    rst = 1'b1;
    #1;
    n_checks++; if (fifo_rst_req !== 1'b0) $display("FAIL midrst fifo_rst_req: got %b want 0", fifo_rst_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_block !== 1'b0) $display("FAIL midrst wr_block: got %b want 0", wr_block); else n_pass++;
    exp_q.delete();
    m_pending = '0; m_free_at = 0; m_auto = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain();
    n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL midrst count: got %0d flushes want %0d", act_q.size(), exp_q.size()); else n_pass++;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (a.done !== e.done) $display("FAIL midrst done_cycle: got %0d want %0d", a.done, e.done); else n_pass++;
      n_checks++; if (a.ack !== e.ack) $display("FAIL midrst ack: got %b want %b", a.ack, e.ack); else n_pass++;
    end
    n_checks++; if (ack_seen !== ack_before) $display("FAIL midrst lost_ack: got %0d ack pulses want %0d", ack_seen, ack_before); else n_pass++;
    n_checks++; if (stray !== 0) $display("FAIL stray_outputs: got %0d cycles want 0", stray); else n_pass++;
    act_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    flush_req = '0;
    clr_timeout = 1'b0;
    test_reset();
    test_auto_init();
    test_single();
    test_coalesce();
    test_ext_idle();
    test_timeout();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
